// File: rtl/systolic_sequencer.sv
// Run-level controller for an N x M output-stationary MAC array: clears the
// accumulators, issues skewed A/B feed enables and operand indices, then signals done.
module systolic_sequencer #(
    parameter int N       = 3,
    parameter int M       = 3,
    parameter int KW      = 8,
    parameter int MAC_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            abort,
    output logic            load,
    output logic [N-1:0]    a_en,
    output logic [M-1:0]    b_en,
    output logic [N*KW-1:0] a_k,
    output logic [M*KW-1:0] b_k,
    output logic            busy,
    output logic            done
);

    // Wide enough for K_max + N + M, so the run counter never wraps.
    localparam int TW = KW + $clog2(N + M) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   last_t;

    logic            load_d, busy_d, done_d;
    logic [N-1:0]    a_en_d;
    logic [M-1:0]    b_en_d;
    logic [N*KW-1:0] a_k_d;
    logic [M*KW-1:0] b_k_d;

    // Final RUN count is T-1 = K+N+M-3; only used while K != 0, so it never underflows.
    assign last_t = TW'(k_q) + TW'(N + M) - TW'(3);

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    k_d     = k_len;
                    t_d     = '0;
                end
            end
            S_CLEAR: begin
                t_d = '0;
                if (abort)           state_d = S_IDLE;
                else if (k_q != '0)  state_d = S_RUN;
                else                 state_d = S_DONE;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                end else if (t_q == last_t) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                end else if (t_q == TW'(MAC_LAT - 1)) begin
                    state_d = S_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        load_d = (state_d == S_CLEAR);
        busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        a_en_d = '0;
        b_en_d = '0;
        a_k_d  = '0;
        b_k_d  = '0;
        if (state_d == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (t_d >= TW'(i) && t_d < TW'(i) + TW'(k_d)) begin
                    a_en_d[i]           = 1'b1;
                    a_k_d[i*KW +: KW]   = KW'(t_d - TW'(i));
                end
            end
            for (int j = 0; j < M; j++) begin
                if (t_d >= TW'(j) && t_d < TW'(j) + TW'(k_d)) begin
                    b_en_d[j]           = 1'b1;
                    b_k_d[j*KW +: KW]   = KW'(t_d - TW'(j));
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            load    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_en    <= '0;
            b_en    <= '0;
            a_k     <= '0;
            b_k     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            load    <= load_d;
            busy    <= busy_d;
            done    <= done_d;
            a_en    <= a_en_d;
            b_en    <= b_en_d;
            a_k     <= a_k_d;
            b_k     <= b_k_d;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: directed scenarios plus random traffic,
// compared every cycle against a pass-timeline reference model.
module tb_systolic_sequencer;

    localparam int N       = 3;
    localparam int M       = 3;
    localparam int KW      = 8;
    localparam int MAC_LAT = 1;
    localparam int OW      = 3 + N + M + N*KW + M*KW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            load, busy, done;
    logic [N-1:0]    a_en;
    logic [M-1:0]    b_en;
    logic [N*KW-1:0] a_k;
    logic [M*KW-1:0] b_k;
    logic [OW-1:0]   dut_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a pass is a timeline indexed by cycles since acceptance.
    bit m_active = 1'b0;
    int m_rel    = 0;
    int m_k      = 0;

    systolic_sequencer #(.N(N), .M(M), .KW(KW), .MAC_LAT(MAC_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k_len (k_len),
        .abort (abort),
        .load  (load),
        .a_en  (a_en),
        .b_en  (b_en),
        .a_k   (a_k),
        .b_k   (b_k),
        .busy  (busy),
        .done  (done)
    );

    assign dut_vec = {load, busy, done, a_en, b_en, a_k, b_k};

    always #5 clk = ~clk;

    function automatic int pass_len(int k);
        return (k == 0) ? 2 : 1 + (k + N + M - 2) + MAC_LAT + 1;
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic            e_load, e_busy, e_done;
        logic [N-1:0]    e_aen;
        logic [M-1:0]    e_ben;
        logic [N*KW-1:0] e_ak;
        logic [M*KW-1:0] e_bk;
        int              len, t;
        e_load = 0; e_busy = 0; e_done = 0;
        e_aen = '0; e_ben = '0; e_ak = '0; e_bk = '0;
        if (m_active) begin
            len    = pass_len(m_k);
            e_load = (m_rel == 0);
            e_done = (m_rel == len - 1);
            e_busy = !e_done;
            if (m_k > 0 && m_rel >= 1 && m_rel <= m_k + N + M - 2) begin
                t = m_rel - 1;
                for (int i = 0; i < N; i++)
                    if (t >= i && t < i + m_k) begin
                        e_aen[i]         = 1'b1;
                        e_ak[i*KW +: KW] = KW'(t - i);
                    end
                for (int j = 0; j < M; j++)
                    if (t >= j && t < j + m_k) begin
                        e_ben[j]         = 1'b1;
                        e_bk[j*KW +: KW] = KW'(t - j);
                    end
            end
        end
        return {e_load, e_busy, e_done, e_aen, e_ben, e_ak, e_bk};
    endfunction

    task automatic model_step();
        if (!rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1'b1;
                m_rel    = 0;
                m_k      = int'(k_len);
            end
        end else if (abort && m_rel != pass_len(m_k) - 1) begin
            m_active = 1'b0;
        end else begin
            m_rel++;
            if (m_rel == pass_len(m_k)) m_active = 1'b0;
        end
    endtask

    // Advance one clock: update the model with the inputs seen at the edge, settle, return.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; k_len = 8'd5;
        tick(); tick();
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, model_out());
        end
        rst = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec, model_out());
        end
    endtask

    task automatic test_nominal();
        int load_c = -1, done_c = -1, a0_first = -1, a0_last = -1, a2_first = -1, b2_first = -1;
        k_len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL nominal_cycle%0d: got %h expected %h", c, dut_vec, model_out());
            end
            if (load) load_c = c;
            if (done) done_c = c;
            if (a_en[0] && a0_first < 0) a0_first = c;
            if (a_en[0]) a0_last = c;
            if (a_en[2] && a2_first < 0) a2_first = c;
            if (b_en[2] && b2_first < 0) b2_first = c;
            if (c >= 4 && c <= 6) begin
                checks++;
                if (a_k[2*KW +: KW] !== KW'(c - 4) || a_en[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL nominal_a_k2: cycle %0d got %0d en %b expected %0d", c, a_k[2*KW +: KW], a_en[2], c - 4);
                end
            end
            tick();
        end
        checks++;
        if (load_c != 1 || done_c != 10) begin
            errors++;
            $display("FAIL nominal_timing: load at %0d done at %0d expected 1 and 10", load_c, done_c);
        end
        checks++;
        if (a0_first != 2 || a0_last != 4 || a2_first != 4 || b2_first != 4) begin
            errors++;
            $display("FAIL nominal_skew: a0 %0d..%0d a2 %0d b2 %0d expected 2..4 4 4", a0_first, a0_last, a2_first, b2_first);
        end
    endtask

    task automatic test_zero_len();
        int load_c = -1, done_c = -1, busy_n = 0, en_n = 0;
        k_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL zero_cycle%0d: got %h expected %h", c, dut_vec, model_out());
            end
            if (load) load_c = c;
            if (done) done_c = c;
            if (busy) busy_n++;
            if (a_en != '0 || b_en != '0) en_n++;
            tick();
        end
        checks++;
        if (load_c != 1 || done_c != 2 || busy_n != 1 || en_n != 0) begin
            errors++;
            $display("FAIL zero_len: load %0d done %0d busy %0d en %0d expected 1 2 1 0", load_c, done_c, busy_n, en_n);
        end
    endtask

    task automatic test_held_start();
        int loads = 0, first = -1, second = -1, done_c = -1;
        k_len = 8'd4; start = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL held_cycle%0d: got %h expected %h", c, dut_vec, model_out());
            end
            if (load) begin
                loads++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
            if (done && done_c < 0) done_c = c;
            tick();
        end
        start = 1'b0;
        checks++;
        if (loads != 2 || first != 1 || done_c != 11 || second != done_c + 2) begin
            errors++;
            $display("FAIL held_start: loads %0d at %0d,%0d done %0d expected 2 at 1,13 done 11", loads, first, second, done_c);
        end
        for (int c = 0; c < 12; c++) tick();
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL held_drain: got %h expected %h", dut_vec, model_out());
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        k_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (dut_vec !== '0 || model_out() !== '0) begin
            errors++;
            $display("FAIL abort_clear: got %h expected 0", dut_vec);
        end
        for (int c = 0; c < 12; c++) begin
            if (done) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
        // Abort in IDLE blocks start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks_start: load %b expected 0", load);
        end
        k_len = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL abort_restart%0d: got %h expected %h", c, dut_vec, model_out());
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL abort_restart_done: got %0d done pulses expected 1", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        k_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got %h expected 0", dut_vec);
        end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (dut_vec !== model_out() || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_stays_idle: got %h expected %h", dut_vec, model_out());
            end
        end
    endtask

    task automatic test_large_k();
        int done_c = -1, max_ak2 = -1, bad = 0;
        k_len = 8'd255; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 266; c++) begin
            if (dut_vec !== model_out()) bad++;
            if (done) done_c = c;
            if (a_en[2] && int'(a_k[2*KW +: KW]) > max_ak2) max_ak2 = int'(a_k[2*KW +: KW]);
            if (c == 258) begin
                checks++;
                if (a_en[2] !== 1'b1 || a_k[2*KW +: KW] !== 8'd254) begin
                    errors++;
                    $display("FAIL large_k_a_k2: en %b got %0d expected 254", a_en[2], a_k[2*KW +: KW]);
                end
            end
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL large_k_trace: %0d cycles differ from model expected 0", bad);
        end
        checks++;
        if (done_c != 262 || max_ak2 != 254) begin
            errors++;
            $display("FAIL large_k_done: done at %0d max a_k2 %0d expected 262 and 254", done_c, max_ak2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            k_len = KW'($urandom_range(0, 12));
            tick();
            checks++;
            if (dut_vec !== model_out()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", cyc, dut_vec, model_out());
            end
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        checks++;
        if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL random_settle: got %h expected %h", dut_vec, model_out());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_held_start();
        test_abort();
        test_reset_mid_run();
        test_large_k();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
